// File: rtl/ladder_line_fetcher.sv
// Per-scanline ladder sprite row fetcher: one shared ROM read per ladder slot per line,
// double-buffered rows, and a registered ladder_on pixel flag for the following line.
//   state | meaning
//   IDLE  | waiting for line_start; shadow holds rows fetched for the next line
//   SCAN  | one slot per cycle, fetching its ROM row into shadow
module ladder_line_fetcher #(
    parameter int NUM_LADDERS = 4,
    parameter int SPRITE_H    = 50,
    parameter int SPRITE_W    = 14,
    localparam int IW         = $clog2(NUM_LADDERS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_start,
    input  logic [9:0]          next_y,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_idx,
    input  logic                cfg_en,
    input  logic [9:0]          cfg_x,
    input  logic [9:0]          cfg_y,
    output logic [5:0]          rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    input  logic [9:0]          draw_x,
    output logic                ladder_on,
    output logic                busy,
    output logic                overrun
);
    localparam int CW               = $clog2(SPRITE_W);
    localparam logic [9:0] H_LIM    = 10'(SPRITE_H);
    localparam logic [9:0] W_LIM    = 10'(SPRITE_W);
    localparam logic [IW-1:0] LAST  = IW'(NUM_LADDERS - 1);
    localparam logic [CW-1:0] MSB   = CW'(SPRITE_W - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [9:0] ty;
    logic load_line, ovr_nxt;

    logic [NUM_LADDERS-1:0] tab_en;
    logic [9:0] tab_x [NUM_LADDERS];
    logic [9:0] tab_y [NUM_LADDERS];

    logic [NUM_LADDERS-1:0] sh_valid, act_valid;
    logic [9:0] sh_x [NUM_LADDERS];
    logic [9:0] act_x [NUM_LADDERS];
    logic [SPRITE_W-1:0] sh_data [NUM_LADDERS];
    logic [SPRITE_W-1:0] act_data [NUM_LADDERS];

    logic [9:0] row;
    logic scan_hit;
    logic [9:0] col [NUM_LADDERS];
    logic [CW-1:0] sel [NUM_LADDERS];
    logic pix_nxt;

    // No vertical wraparound: ty below the ladder top is a miss, not a huge row.
    assign row      = ty - tab_y[idx];
    assign scan_hit = (state == SCAN) && tab_en[idx] && (ty >= tab_y[idx]) && (row < H_LIM);
    assign rom_addr = scan_hit ? row[5:0] : 6'd0;
    assign busy     = (state == SCAN);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load_line = 1'b0;
        ovr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                    load_line = 1'b1;
                end
            end
            SCAN: begin
                if (line_start) begin
                    idx_nxt   = '0;
                    load_line = 1'b1;
                    ovr_nxt   = 1'b1;
                end else if (idx == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            ty      <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            overrun <= ovr_nxt;
            if (load_line)
                ty <= next_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_en <= '0;
            for (int i = 0; i < NUM_LADDERS; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
            end
        end else if (cfg_we) begin
            tab_en[cfg_idx] <= cfg_en;
            tab_x[cfg_idx]  <= cfg_x;
            tab_y[cfg_idx]  <= cfg_y;
        end
    end

    // A restart mid-scan leaves shadow partially refreshed, so active is blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid  <= '0;
            act_valid <= '0;
            for (int i = 0; i < NUM_LADDERS; i++) begin
                sh_x[i]     <= '0;
                sh_data[i]  <= '0;
                act_x[i]    <= '0;
                act_data[i] <= '0;
            end
        end else begin
            if (load_line) begin
                if (state == SCAN) begin
                    act_valid <= '0;
                end else begin
                    act_valid <= sh_valid;
                    act_x     <= sh_x;
                    act_data  <= sh_data;
                end
            end
            if (state == SCAN) begin
                sh_valid[idx] <= scan_hit;
                if (scan_hit) begin
                    sh_x[idx]    <= tab_x[idx];
                    sh_data[idx] <= rom_data;
                end
            end
        end
    end

    // Bit SPRITE_W-1 of a row is the leftmost pixel; no horizontal wraparound.
    always_comb begin
        pix_nxt = 1'b0;
        for (int i = 0; i < NUM_LADDERS; i++) begin
            col[i] = draw_x - act_x[i];
            sel[i] = MSB - col[i][CW-1:0];
            if (act_valid[i] && (draw_x >= act_x[i]) && (col[i] < W_LIM))
                pix_nxt = pix_nxt | act_data[i][sel[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ladder_on <= 1'b0;
        else
            ladder_on <= pix_nxt;
    end
endmodule

// File: tb/tb_ladder_line_fetcher.sv
// Scoreboard bench for ladder_line_fetcher: a line-level model predicts ROM addresses,
// overrun pulses and pixel output; a negedge monitor pops and compares.
module tb_ladder_line_fetcher;
    localparam int N = 4;
    localparam int H = 50;
    localparam int W = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_start = 1'b0;
    logic [9:0] next_y = '0;
    logic cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic cfg_en = 1'b0;
    logic [9:0] cfg_x = '0;
    logic [9:0] cfg_y = '0;
    logic [5:0] rom_addr;
    logic [13:0] rom_data;
    logic [9:0] draw_x = '0;
    logic ladder_on, busy, overrun;

    ladder_line_fetcher #(.NUM_LADDERS(N), .SPRITE_H(H), .SPRITE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_y(next_y),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .draw_x(draw_x),
        .ladder_on(ladder_on), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Rails on the outer two columns, full rungs every 4th row, asymmetric marks elsewhere.
    function automatic logic [13:0] rom_row(int r);
        logic [13:0] v;
        if (r >= H) return 14'd0;
        if (r % 4 == 3) return 14'h3FFF;
        if (r == 1) return 14'h3003;
        v = 14'(r) << 3;
        return 14'h3003 | v;
    endfunction

    assign rom_data = rom_row(int'(rom_addr));

    typedef struct {logic v; int x; logic [13:0] d;} slot_t;
    typedef struct {int due; int val;} exp_t;

    logic tb_en [N];
    int tb_x [N];
    int tb_y [N];
    slot_t m_active [N];
    slot_t m_pending [N];
    int busy_until = -100;
    exp_t rom_q [$];
    exp_t ovr_q [$];
    exp_t pix_q [$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int pix_model(int dx);
        int res = 0;
        for (int i = 0; i < N; i++)
            if (m_active[i].v && dx >= m_active[i].x && dx - m_active[i].x < W)
                res = res | int'(m_active[i].d[13 - (dx - m_active[i].x)]);
        return res;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            tb_en[i] = 1'b0; tb_x[i] = 0; tb_y[i] = 0;
            m_active[i] = '{1'b0, 0, 14'd0};
            m_pending[i] = '{1'b0, 0, 14'd0};
        end
        busy_until = -100;
        rom_q.delete(); ovr_q.delete(); pix_q.delete();
    endfunction

    // Line-level model: the whole fetch for a line is decided from the table at line_start.
    function automatic void model_line(int c, int ny);
        int r;
        if (c <= busy_until) begin
            ovr_q.push_back('{c + 1, 1});
            for (int i = 0; i < N; i++) m_active[i].v = 1'b0;
            while (rom_q.size() > 0 && rom_q[$].due > c) void'(rom_q.pop_back());
        end else begin
            m_active = m_pending;
        end
        for (int i = 0; i < N; i++) begin
            r = ny - tb_y[i];
            if (tb_en[i] && ny >= tb_y[i] && r < H) begin
                m_pending[i] = '{1'b1, tb_x[i], rom_row(r)};
                rom_q.push_back('{c + 1 + i, r});
            end else begin
                m_pending[i].v = 1'b0;
                rom_q.push_back('{c + 1 + i, 0});
            end
        end
        busy_until = c + N;
    endfunction

    task automatic tick();
        int c = cyc;
        pix_q.push_back('{c + 1, pix_model(int'(draw_x))});
        if (cfg_we) begin
            tb_en[cfg_idx] = cfg_en;
            tb_x[cfg_idx] = int'(cfg_x);
            tb_y[cfg_idx] = int'(cfg_y);
        end
        if (line_start) model_line(c, int'(next_y));
        @(posedge clk);
        #1;
        line_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic line(input int ny);
        next_y = 10'(ny);
        line_start = 1'b1;
        tick();
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int dx = lo; dx <= hi; dx++) begin
            draw_x = 10'(dx);
            tick();
        end
    endtask

    task automatic cfg(input int i, input logic en, input int x, input int y);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_en = en; cfg_x = 10'(x); cfg_y = 10'(y);
        tick();
    endtask

    function automatic logic [9:0] pick_dx();
        if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
        return 10'(tb_x[$urandom_range(0, N - 1)] + $urandom_range(0, 15));
    endfunction

    task automatic rand_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            draw_x = pick_dx();
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (rom_q.size() > 0 && rom_q[0].due < cyc) begin
                void'(rom_q.pop_front());
                check("busy_missing", 0, 1);
            end
            if (busy) begin
                if (rom_q.size() == 0 || rom_q[0].due != cyc) begin
                    check("busy_extra", 1, 0);
                end else begin
                    mon_e = rom_q.pop_front();
                    check("rom_addr", int'(rom_addr), mon_e.val);
                end
            end else begin
                check("rom_addr_idle", int'(rom_addr), 0);
            end
            while (ovr_q.size() > 0 && ovr_q[0].due < cyc) begin
                void'(ovr_q.pop_front());
                check("overrun_missing", 0, 1);
            end
            if (overrun) begin
                if (ovr_q.size() == 0 || ovr_q[0].due != cyc) begin
                    check("overrun_extra", 1, 0);
                end else begin
                    mon_e = ovr_q.pop_front();
                    check("overrun", int'(overrun), mon_e.val);
                end
            end
            while (pix_q.size() > 0 && pix_q[0].due < cyc) void'(pix_q.pop_front());
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                mon_e = pix_q.pop_front();
                check("ladder_on", int'(ladder_on), mon_e.val);
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_ladder_on", int'(ladder_on), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // single ladder, vertical bounds, no vertical wraparound
        cfg(0, 1'b1, 100, 200);
        line(203); sweep(90, 120);
        line(201); sweep(90, 120);
        line(199); sweep(90, 120);
        line(250); sweep(90, 120);
        line(249); sweep(90, 120);
        line(0);   sweep(90, 120);
        cfg(0, 1'b1, 100, 1000);
        line(5); sweep(90, 120);
        line(6); sweep(90, 120);

        // four slots sharing the ROM, overlap at x=10..13
        cfg(0, 1'b1, 0, 100);
        cfg(1, 1'b1, 10, 100);
        cfg(2, 1'b1, 300, 100);
        cfg(3, 1'b1, 600, 100);
        line(110); sweep(0, 30);
        line(111); sweep(0, 30); sweep(295, 320); sweep(595, 620);

        // overrun: second line_start two cycles after the first
        line(120); sweep(0, 0);
        line(105); sweep(0, 30);
        line(130); sweep(0, 30);

        // config write to slot1 during slot1's scan cycle
        line(102); draw_x = 10'd5; tick();
        cfg(1, 1'b1, 400, 100);
        sweep(0, 30);
        line(103); sweep(0, 30); sweep(395, 420);
        line(104); sweep(0, 30); sweep(395, 420);

        // asynchronous reset in the middle of a scan
        draw_x = 10'd0;
        line(105);
        #2;
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_ladder_on", int'(ladder_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg(0, 1'b1, 100, 200);
        line(203); sweep(90, 120);
        line(201); sweep(90, 120);

        // randomized configurations, lines and occasional overruns
        for (int it = 0; it < 25; it++) begin
            rand_ticks(N + 1);
            for (int s = 0; s < N; s++)
                if ($urandom_range(0, 1) == 1)
                    cfg(s, ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 5) == 0) ? 1015 : $urandom_range(0, 1023),
                        $urandom_range(0, 1023));
            line(tb_y[$urandom_range(0, N - 1)] + $urandom_range(0, 55) - 3);
            if ($urandom_range(0, 4) == 0) begin
                rand_ticks($urandom_range(0, N - 1));
                line(tb_y[$urandom_range(0, N - 1)] + $urandom_range(0, 55));
            end
            rand_ticks(30);
        end

        rand_ticks(N + 2);
        check("rom_q_drained", rom_q.size(), 0);
        check("ovr_q_drained", ovr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
